// File: rtl/egg_timer_ctrl.sv
// MM:SS BCD countdown controller for the egg timer: set, start, pause, resume and clear.
// It decrements once per TICK_DIV cycles while running and flashes the display in DONE.
module egg_timer_ctrl #(
   parameter int TICK_DIV = 50000000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_clear,
   input  logic       btn_start,
   input  logic       btn_inc_min,
   input  logic       btn_inc_sec,
   output logic [3:0] min_tens,
   output logic [3:0] min_ones,
   output logic [3:0] sec_tens,
   output logic [3:0] sec_ones,
   output logic [3:0] blank,
   output logic       running,
   output logic       done
);

   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] CNT_MAX  = CW'(TICK_DIV - 1);
   localparam logic [CW-1:0] CNT_HALF = CW'(TICK_DIV / 2);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_PAUSE = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]    r_state, w_state_nxt;
   logic [3:0]    r_mt, r_mo, r_st, r_so;
   logic [3:0]    w_mt_nxt, w_mo_nxt, w_st_nxt, w_so_nxt;
   logic [3:0]    w_inc_mt, w_inc_mo, w_inc_st, w_inc_so;
   logic [3:0]    w_dec_mt, w_dec_mo, w_dec_st, w_dec_so;
   logic [CW-1:0] r_cnt, w_cnt_nxt, r_blink, w_blink_nxt;
   logic [3:0]    r_blank;
   logic          r_running, r_done;
   logic          w_zero, w_dec_zero, w_tick;

   assign w_zero     = ({r_mt, r_mo, r_st, r_so} == 16'h0000);
   assign w_tick     = (r_state == S_RUN) && (r_cnt == CNT_MAX);
   assign w_dec_zero = ({w_dec_mt, w_dec_mo, w_dec_st, w_dec_so} == 16'h0000);

   // Seconds wrap 59 -> 00 without touching minutes; minutes wrap 99 -> 00.
   always_comb begin
      w_inc_mt = r_mt;
      w_inc_mo = r_mo;
      w_inc_st = r_st;
      w_inc_so = r_so;
      if (btn_inc_sec) begin
         if (r_so == 4'd9) begin
            w_inc_so = 4'd0;
            w_inc_st = (r_st == 4'd5) ? 4'd0 : r_st + 4'd1;
         end else begin
            w_inc_so = r_so + 4'd1;
         end
      end
      if (btn_inc_min) begin
         if (r_mo == 4'd9) begin
            w_inc_mo = 4'd0;
            w_inc_mt = (r_mt == 4'd9) ? 4'd0 : r_mt + 4'd1;
         end else begin
            w_inc_mo = r_mo + 4'd1;
         end
      end
   end

   always_comb begin
      w_dec_mt = r_mt;
      w_dec_mo = r_mo;
      w_dec_st = r_st;
      w_dec_so = r_so;
      if (!w_zero) begin
         if (r_so != 4'd0) begin
            w_dec_so = r_so - 4'd1;
         end else begin
            w_dec_so = 4'd9;
            if (r_st != 4'd0) begin
               w_dec_st = r_st - 4'd1;
            end else begin
               w_dec_st = 4'd5;
               if (r_mo != 4'd0) begin
                  w_dec_mo = r_mo - 4'd1;
               end else begin
                  w_dec_mo = 4'd9;
                  w_dec_mt = r_mt - 4'd1;
               end
            end
         end
      end
   end

   // A start pulse outranks a coincident tick: the state changes and the value holds.
   always_comb begin
      w_state_nxt = r_state;
      w_mt_nxt    = r_mt;
      w_mo_nxt    = r_mo;
      w_st_nxt    = r_st;
      w_so_nxt    = r_so;
      if (btn_clear) begin
         w_state_nxt = S_IDLE;
         w_mt_nxt    = 4'd0;
         w_mo_nxt    = 4'd0;
         w_st_nxt    = 4'd0;
         w_so_nxt    = 4'd0;
      end else if (btn_start) begin
         case (r_state)
            S_IDLE:  w_state_nxt = w_zero ? S_IDLE : S_RUN;
            S_RUN:   w_state_nxt = S_PAUSE;
            S_PAUSE: w_state_nxt = S_RUN;
            default: w_state_nxt = S_IDLE;
         endcase
      end else begin
         case (r_state)
            S_IDLE: begin
               w_mt_nxt = w_inc_mt;
               w_mo_nxt = w_inc_mo;
               w_st_nxt = w_inc_st;
               w_so_nxt = w_inc_so;
            end
            S_RUN: begin
               if (w_tick) begin
                  w_mt_nxt = w_dec_mt;
                  w_mo_nxt = w_dec_mo;
                  w_st_nxt = w_dec_st;
                  w_so_nxt = w_dec_so;
                  if (w_dec_zero) w_state_nxt = S_DONE;
               end
            end
            default: ;
         endcase
      end
   end

   // The tick counter freezes across a pause so a resume finishes the interrupted second.
   always_comb begin
      if (r_state == S_RUN && w_state_nxt == S_RUN)
         w_cnt_nxt = (r_cnt == CNT_MAX) ? '0 : r_cnt + 1'b1;
      else if (w_state_nxt == S_PAUSE || (r_state == S_PAUSE && w_state_nxt == S_RUN))
         w_cnt_nxt = r_cnt;
      else
         w_cnt_nxt = '0;

      if (r_state == S_DONE && w_state_nxt == S_DONE)
         w_blink_nxt = (r_blink == CNT_MAX) ? '0 : r_blink + 1'b1;
      else
         w_blink_nxt = '0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_mt      <= 4'd0;
         r_mo      <= 4'd0;
         r_st      <= 4'd0;
         r_so      <= 4'd0;
         r_cnt     <= '0;
         r_blink   <= '0;
         r_blank   <= 4'b0000;
         r_running <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_mt      <= w_mt_nxt;
         r_mo      <= w_mo_nxt;
         r_st      <= w_st_nxt;
         r_so      <= w_so_nxt;
         r_cnt     <= w_cnt_nxt;
         r_blink   <= w_blink_nxt;
         r_blank   <= (w_state_nxt == S_DONE && w_blink_nxt >= CNT_HALF) ? 4'b1111 : 4'b0000;
         r_running <= (w_state_nxt == S_RUN);
         r_done    <= (w_state_nxt == S_DONE);
      end
   end

   assign min_tens = r_mt;
   assign min_ones = r_mo;
   assign sec_tens = r_st;
   assign sec_ones = r_so;
   assign blank    = r_blank;
   assign running  = r_running;
   assign done     = r_done;

endmodule

// File: tb/tb_egg_timer_ctrl.sv
// Scoreboard bench for egg_timer_ctrl: directed scenarios then random button traffic,
// each cycle's expected outputs come from a minutes/seconds reference model.
module tb_egg_timer_ctrl;

   localparam int TD = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       btn_clear = 1'b0;
   logic       btn_start = 1'b0;
   logic       btn_inc_min = 1'b0;
   logic       btn_inc_sec = 1'b0;
   logic [3:0] min_tens, min_ones, sec_tens, sec_ones, blank;
   logic       running, done;

   egg_timer_ctrl #(.TICK_DIV(TD)) dut (
      .clk(clk), .reset(reset), .btn_clear(btn_clear), .btn_start(btn_start),
      .btn_inc_min(btn_inc_min), .btn_inc_sec(btn_inc_sec),
      .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
      .blank(blank), .running(running), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0] mt, mo, st, so, bl;
      logic       run, dn;
   } obs_t;

   obs_t q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   // Reference model: mode 0 idle, 1 run, 2 pause, 3 done; time kept as minutes and seconds.
   int m_mode = 0, m_min = 0, m_sec = 0, m_cnt = 0, m_blk = 0;

   task automatic model_step(input bit rs, input bit cl, input bit sa, input bit im, input bit is);
      int total;
      total = m_min * 60 + m_sec;
      if (rs) begin
         m_mode = 0; m_min = 0; m_sec = 0; m_cnt = 0; m_blk = 0;
      end else if (cl) begin
         m_mode = 0; m_min = 0; m_sec = 0; m_cnt = 0;
      end else if (sa) begin
         if (m_mode == 0) begin
            if (total != 0) begin m_mode = 1; m_cnt = 0; end
         end else if (m_mode == 1) m_mode = 2;
         else if (m_mode == 2) m_mode = 1;
         else begin m_mode = 0; m_cnt = 0; end
      end else if (m_mode == 0) begin
         if (is) m_sec = (m_sec + 1) % 60;
         if (im) m_min = (m_min + 1) % 100;
      end else if (m_mode == 1) begin
         if (m_cnt == TD - 1) begin
            m_cnt = 0;
            total = total - 1;
            m_min = total / 60;
            m_sec = total % 60;
            if (total == 0) begin m_mode = 3; m_blk = 0; end
         end else m_cnt = m_cnt + 1;
      end else if (m_mode == 3) begin
         m_blk = (m_blk + 1) % TD;
      end
   endtask

   function automatic obs_t model_obs();
      obs_t o;
      o.mt  = 4'(m_min / 10);
      o.mo  = 4'(m_min % 10);
      o.st  = 4'(m_sec / 10);
      o.so  = 4'(m_sec % 10);
      o.bl  = (m_mode == 3 && m_blk >= TD / 2) ? 4'hF : 4'h0;
      o.run = (m_mode == 1);
      o.dn  = (m_mode == 3);
      return o;
   endfunction

   task automatic cyc(input bit rs, input bit cl, input bit sa, input bit im, input bit is);
      @(negedge clk);
      reset = rs; btn_clear = cl; btn_start = sa; btn_inc_min = im; btn_inc_sec = is;
      model_step(rs, cl, sa, im, is);
      q.push_back(model_obs());
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
   endtask

   initial begin : monitor
      obs_t e, a;
      forever begin
         @(posedge clk);
         #2;
         if (q.size() > 0) begin
            e = q.pop_front();
            a = '{min_tens, min_ones, sec_tens, sec_ones, blank, running, done};
            n_cmp++;
            if (a !== e) begin
               n_bad++;
               $display("FAIL outputs t=%0t got %0d%0d:%0d%0d bl=%h run=%b dn=%b exp %0d%0d:%0d%0d bl=%h run=%b dn=%b",
                        $time, a.mt, a.mo, a.st, a.so, a.bl, a.run, a.dn,
                        e.mt, e.mo, e.st, e.so, e.bl, e.run, e.dn);
            end
         end
      end
   end

   initial begin : stim
      cyc(1, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0);
      // 01:03 then count through the 01:00 -> 00:59 borrow
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1);
      cyc(0, 0, 0, 1, 0);
      idle(2);
      cyc(0, 0, 1, 0, 0);
      idle(20);
      // 00:02, pause with the counter at 2, hold, resume
      cyc(0, 1, 0, 0, 0);
      cyc(0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 1);
      cyc(0, 0, 1, 0, 0);
      idle(2);
      cyc(0, 0, 1, 0, 0);
      idle(20);
      cyc(0, 0, 1, 0, 0);
      // run to expiry, watch the blink, acknowledge
      idle(16);
      cyc(0, 0, 1, 0, 0);
      idle(2);
      // wrap of both fields
      for (int i = 0; i < 60; i++) cyc(0, 0, 0, 0, 1);
      for (int i = 0; i < 100; i++) cyc(0, 0, 0, 1, 0);
      cyc(0, 0, 0, 1, 1);
      cyc(0, 0, 1, 0, 0);
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 1);
      cyc(0, 0, 1, 0, 0);
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 1);
      cyc(0, 0, 1, 0, 0);
      idle(2);
      cyc(0, 1, 1, 0, 0);
      // reset while in DONE, then start at 00:00
      cyc(0, 0, 0, 0, 1);
      cyc(0, 0, 1, 0, 0);
      idle(6);
      cyc(1, 0, 0, 0, 0);
      cyc(0, 0, 1, 0, 0);
      idle(3);
      // a start landing exactly on a tick
      cyc(0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 1);
      cyc(0, 0, 1, 0, 0);
      idle(3);
      cyc(0, 0, 1, 0, 0);
      idle(2);
      cyc(0, 0, 1, 0, 0);
      idle(3);
      // random traffic
      for (int i = 0; i < 5000; i++) begin
         cyc($urandom_range(0, 599) == 0,
             $urandom_range(0, 199) == 0,
             $urandom_range(0, 13) == 0,
             $urandom_range(0, 29) == 0,
             $urandom_range(0, 5) == 0);
      end
      idle(2);
      @(posedge clk);
      #3;
      n_cmp++;
      if (q.size() != 0) begin
         n_bad++;
         $display("FAIL drain got %0d pending, need 0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
